// File: rtl/pingpong_sram_bank_pkg.sv
// Shared definitions for the ping-pong SRAM bank.
//  - pp_state_e : control FSM encoding (INIT / RUN / SWAP)
//  - MACRO_W_DEF: physical word width of the single-port SRAM macro
package pingpong_sram_bank_pkg;

    localparam int MACRO_W_DEF = 48;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2
    } pp_state_e;

endpackage

// File: rtl/RM_IHPSG13_1P.sv
// Behavioural model of an RM_IHPSG13 single-port SRAM macro.
// Ports:
//  A_CLK              clock
//  A_MEN/A_WEN/A_REN  macro enable, write enable, read enable
//  A_ADDR, A_DIN      word address and write data
//  A_BM               per-bit write mask (1 = write the bit)
//  A_DOUT             registered read data, holds between reads
//  A_BIST_*           BIST port; selected over the functional port when A_BIST_EN=1
module RM_IHPSG13_1P #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 48
) (
    input  logic              A_CLK,
    input  logic              A_MEN,
    input  logic              A_WEN,
    input  logic              A_REN,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DIN,
    input  logic [DATA_W-1:0] A_BM,
    output logic [DATA_W-1:0] A_DOUT,
    input  logic              A_BIST_EN,
    input  logic              A_BIST_MEN,
    input  logic              A_BIST_WEN,
    input  logic              A_BIST_REN,
    input  logic [ADDR_W-1:0] A_BIST_ADDR,
    input  logic [DATA_W-1:0] A_BIST_DIN,
    input  logic [DATA_W-1:0] A_BIST_BM
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              men;
    logic              wen;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] bm;

    always_comb begin
        men  = A_BIST_EN ? A_BIST_MEN  : A_MEN;
        wen  = A_BIST_EN ? A_BIST_WEN  : A_WEN;
        ren  = A_BIST_EN ? A_BIST_REN  : A_REN;
        addr = A_BIST_EN ? A_BIST_ADDR : A_ADDR;
        din  = A_BIST_EN ? A_BIST_DIN  : A_DIN;
        bm   = A_BIST_EN ? A_BIST_BM   : A_BM;
    end

    always_ff @(posedge A_CLK) begin
        if (men) begin
            if (wen) begin
                mem[addr] <= (mem[addr] & ~bm) | (din & bm);
            end else if (ren) begin
                A_DOUT <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sp_sram_bank.sv
// One ping-pong bank: wraps a single RM_IHPSG13 macro.
// Write data is zero-padded from DATA_W up to MACRO_W; read data is truncated
// back to DATA_W. Byte/bit mask is all ones and the BIST port is tied off.
// Ports:
//  clk             clock
//  men, wen, ren   macro enable / write enable / read enable
//  addr            word address
//  din             write data (DATA_W)
//  dout            read data (DATA_W), one cycle after a read, held otherwise
module sp_sram_bank
    import pingpong_sram_bank_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MACRO_W = MACRO_W_DEF
) (
    input  logic              clk,
    input  logic              men,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [MACRO_W-1:0] din_pad;
    logic [MACRO_W-1:0] dout_full;

    assign din_pad = MACRO_W'(din);
    assign dout    = dout_full[DATA_W-1:0];

    RM_IHPSG13_1P #(
        .ADDR_W (ADDR_W),
        .DATA_W (MACRO_W)
    ) u_macro (
        .A_CLK       (clk),
        .A_MEN       (men),
        .A_WEN       (wen),
        .A_REN       (ren),
        .A_ADDR      (addr),
        .A_DIN       (din_pad),
        .A_BM        ({MACRO_W{1'b1}}),
        .A_DOUT      (dout_full),
        .A_BIST_EN   (1'b0),
        .A_BIST_MEN  (1'b0),
        .A_BIST_WEN  (1'b0),
        .A_BIST_REN  (1'b0),
        .A_BIST_ADDR ({ADDR_W{1'b0}}),
        .A_BIST_DIN  ({MACRO_W{1'b0}}),
        .A_BIST_BM   ({MACRO_W{1'b0}})
    );

    // Padding bits always read back as zero and are intentionally dropped.
    generate
        if (MACRO_W > DATA_W) begin : g_trunc
            logic unused_pad;
            assign unused_pad = ^dout_full[MACRO_W-1:DATA_W];
        end
    endgenerate

endmodule

// File: rtl/pingpong_sram_bank.sv
// Ping-pong buffer from two single-port SRAM banks, emulating a 1W/1R memory.
// The writer fills bank bank_w while the reader drains bank ~bank_w; roles swap
// once both sides have signalled frame done (wr_done / rd_done).
// Ports:
//  clk, rst_n                  clock, asynchronous active-low reset
//  wr_en, wr_addr, wr_data     write strobe/address/data, accepted when wr_ready
//  wr_done                     writer frame-done pulse
//  wr_ready                    write bank open
//  rd_en, rd_addr              read strobe/address, accepted when rd_ready
//  rd_done                     reader frame-done pulse
//  rd_ready                    read bank holds a complete frame
//  rd_data, rd_valid           read data, valid one cycle after an accepted read
//  bank_w                      current write bank index
//  swap_pulse                  one-cycle pulse while the banks exchange roles
//  ovf_err                     one-cycle pulse on a strobe while not ready
// Handshake: a strobe (wr_en / rd_en) takes effect only in a cycle where the
// matching ready is high; a strobe with ready low is dropped and flagged on ovf_err.
module pingpong_sram_bank
    import pingpong_sram_bank_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MACRO_W = MACRO_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              bank_w,
    output logic              swap_pulse,
    output logic              ovf_err
);

    pp_state_e         state_q, state_d;
    logic              bank_w_q;
    logic              wr_fin_q, wr_fin_d;
    logic              rd_fin_q, rd_fin_d;
    logic              rd_valid_q;
    logic              rd_bank_q;
    logic [DATA_W-1:0] rd_hold_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              men0, wen0, ren0;
    logic              men1, wen1, ren1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] dout0, dout1;

    // Control FSM: next state, flags and ready/swap outputs.
    always_comb begin
        state_d    = state_q;
        wr_fin_d   = wr_fin_q;
        rd_fin_d   = rd_fin_q;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        swap_pulse = 1'b0;
        case (state_q)
            ST_INIT: begin
                // No complete frame yet; rd_done is ignored here.
                wr_ready = 1'b1;
                if (wr_done) begin
                    state_d = ST_SWAP;
                end
            end
            ST_RUN: begin
                wr_ready = !wr_fin_q;
                rd_ready = !rd_fin_q;
                wr_fin_d = wr_fin_q | wr_done;
                rd_fin_d = rd_fin_q | rd_done;
                if (wr_fin_d && rd_fin_d) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                swap_pulse = 1'b1;
                wr_fin_d   = 1'b0;
                rd_fin_d   = 1'b0;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign wr_acc  = wr_en & wr_ready;
    assign rd_acc  = rd_en & rd_ready;
    assign ovf_err = (wr_en & ~wr_ready) | (rd_en & ~rd_ready);
    assign bank_w  = bank_w_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            bank_w_q   <= 1'b0;
            wr_fin_q   <= 1'b0;
            rd_fin_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_fin_q   <= wr_fin_d;
            rd_fin_q   <= rd_fin_d;
            rd_valid_q <= rd_acc;
            if (state_q == ST_SWAP) begin
                bank_w_q <= ~bank_w_q;
            end
            // Remember which bank served the read so a read issued just before
            // a swap still returns data from the right macro.
            if (rd_acc) begin
                rd_bank_q <= ~bank_w_q;
            end
            if (rd_valid_q) begin
                rd_hold_q <= rd_data;
            end
        end
    end

    // Write bank sees only write traffic, read bank only read traffic, so a
    // single macro is never written and read in the same cycle.
    always_comb begin
        men0  = bank_w_q ? rd_acc : wr_acc;
        wen0  = ~bank_w_q & wr_acc;
        ren0  = bank_w_q & rd_acc;
        addr0 = bank_w_q ? rd_addr : wr_addr;
        men1  = bank_w_q ? wr_acc : rd_acc;
        wen1  = bank_w_q & wr_acc;
        ren1  = ~bank_w_q & rd_acc;
        addr1 = bank_w_q ? wr_addr : rd_addr;
    end

    sp_sram_bank #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MACRO_W (MACRO_W)
    ) u_bank0 (
        .clk  (clk),
        .men  (men0),
        .wen  (wen0),
        .ren  (ren0),
        .addr (addr0),
        .din  (wr_data),
        .dout (dout0)
    );

    sp_sram_bank #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MACRO_W (MACRO_W)
    ) u_bank1 (
        .clk  (clk),
        .men  (men1),
        .wen  (wen1),
        .ren  (ren1),
        .addr (addr1),
        .din  (wr_data),
        .dout (dout1)
    );

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? (rd_bank_q ? dout1 : dout0) : rd_hold_q;

endmodule
